// File: rtl/button_event_pkg.sv
// Shared types and defaults for the button event decoder.
// Timing defaults assume a 100 MHz system clock.
package button_event_pkg;

  localparam int unsigned LONG_PRESS_DEFAULT   = 32'd50_000_000;
  localparam int unsigned DOUBLE_CLICK_DEFAULT = 32'd25_000_000;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_t;

endpackage

// File: rtl/button_edge_detect.sv
// Registers the button level and derives rise/fall strobes.
// prev clears on reset so a held button looks like a fresh rise.
module button_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/button_event_decoder.sv
// Decodes a clean button level into press/release, click,
// double-click and long-press events with registered outputs.
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_PRESS_TIME     = LONG_PRESS_DEFAULT,
  parameter int unsigned DOUBLE_CLICK_WINDOW = DOUBLE_CLICK_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic press,
  output logic release_pulse,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic held
);

  localparam logic [31:0] LP_LAST = 32'(LONG_PRESS_TIME - 1);
  localparam logic [31:0] DC_LAST = 32'(DOUBLE_CLICK_WINDOW - 1);

  state_t      state;
  logic [31:0] cnt;
  logic        rise;
  logic        fall;

  button_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .level (button_in),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      single_click  <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      held          <= 1'b0;
    end else begin
      press         <= rise;
      release_pulse <= fall;
      single_click  <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESSED;
            cnt   <= '0;
          end
        end
        // a release on the terminal cycle beats the long press
        PRESSED: begin
          if (fall) begin
            state <= WAIT_SECOND;
            cnt   <= '0;
          end else if (cnt == LP_LAST) begin
            long_press <= 1'b1;
            held       <= 1'b1;
            state      <= LONG_HELD;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        LONG_HELD: begin
          if (fall) begin
            held  <= 1'b0;
            state <= IDLE;
          end
        end
        // a second press on the terminal cycle beats the single click
        WAIT_SECOND: begin
          if (rise) begin
            double_click <= 1'b1;
            state        <= SECOND_PRESSED;
            cnt          <= '0;
          end else if (cnt == DC_LAST) begin
            single_click <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        SECOND_PRESSED: begin
          if (fall) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 Parameter LONG_PRESS_TIME, default 50000000, is the number of held cycles before a long press is declared (0.5 s at 100 MHz).
REQ-002 Parameter DOUBLE_CLICK_WINDOW, default 25000000, is the number of released cycles allowed before a second press (0.25 s at 100 MHz).
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 button_in  input  1  debounced, already-synchronised button level (1 = pressed).
REQ-006 press  output  1  one-cycle pulse on each 0->1 edge of button_in.
REQ-007 release  output  1  one-cycle pulse on each 1->0 edge of button_in.
REQ-008 single_click  output  1  one-cycle pulse when a short press is not followed by a second press within the window.
REQ-009 double_click  output  1  one-cycle pulse when a second press starts within the window.
REQ-010 long_press  output  1  one-cycle pulse when a hold reaches LONG_PRESS_TIME.
REQ-011 held  output  1  level; high while a long press is in progress.

Function
REQ-012 The block SHALL register button_in into prev; rise = button_in & ~prev; fall = ~button_in & prev.
REQ-013 All outputs SHALL be registered, with press/release asserted in the cycle after the edge is sampled (latency 1).
REQ-014 The FSM SHALL have the states IDLE, PRESSED, LONG_HELD, WAIT_SECOND and SECOND_PRESSED.
REQ-015 IDLE: on rise, go to PRESSED and clear the counter.
REQ-016 PRESSED: increment the counter each cycle; fall -> WAIT_SECOND with the counter cleared; counter == LONG_PRESS_TIME-1 while still held -> pulse long_press and go to LONG_HELD.
REQ-017 In PRESSED, if fall and the long-press terminal count occur in the same cycle, fall SHALL win: go to WAIT_SECOND with no long_press.
REQ-018 LONG_HELD: keep held = 1; on fall, go to IDLE with held = 0 and no click pulse.
REQ-019 WAIT_SECOND: increment the counter each cycle; rise -> pulse double_click and go to SECOND_PRESSED; counter == DOUBLE_CLICK_WINDOW-1 with no rise -> pulse single_click and go to IDLE.
REQ-020 In WAIT_SECOND, if rise and the window terminal count occur in the same cycle, rise SHALL win: double_click only.
REQ-021 SECOND_PRESSED: ignore hold duration (no long_press); on fall, go to IDLE.
REQ-022 The counter SHALL be 32 bits, unsigned, and never wrap within a state (cleared on every state change).
REQ-023 At most one of single_click, double_click and long_press SHALL be high in any cycle.
REQ-024 press/release SHALL pulse independently of the FSM state and may coincide with double_click.
REQ-025 Both parameters SHALL be >= 2; smaller values are unsupported.

Reset
REQ-026 While reset = 0, the state SHALL be IDLE, counter = 0, prev = 0, and all outputs = 0, asynchronously.
REQ-027 On reset mid-operation (any state), no pulse SHALL be emitted on reset deassertion unless a fresh edge is seen.
REQ-028 If button_in = 1 at reset release, the first sampled cycle SHALL be treated as a rise (prev resets to 0).

Structure
REQ-029 The shared package button_event_pkg SHALL hold the state enumeration encoding and the default values of LONG_PRESS_TIME and DOUBLE_CLICK_WINDOW.
REQ-030 Edge detection (prev register, rise and fall) SHALL be a sub-module, button_edge_detect, instantiated once.
REQ-031 The FSM, counter and output registers SHALL reside in button_event_decoder itself.

Verification (bench parameters LONG_PRESS_TIME = 8, DOUBLE_CLICK_WINDOW = 6)
REQ-032 Hold 3 cycles, release, idle 10 cycles -> press, release, then single_click exactly once, 6 cycles after the release is sampled.
REQ-033 Hold 3, release 2, hold 3, release -> double_click coincident with the second press pulse; no single_click; no long_press.
REQ-034 Hold 20 cycles -> long_press once on the 8th held cycle; held = 1 until release; no click pulses after release.
REQ-035 Release in the same cycle as the long-press terminal count -> no long_press; single_click follows after 6 cycles.
REQ-036 Second rise on the window terminal-count cycle -> double_click only; no single_click.
REQ-037 Assert reset during PRESSED with button still high, then release reset -> all outputs 0 during reset; after release, press pulses once and the FSM restarts in PRESSED.
